// File: rtl/switch_debounce.sv
// Per-channel synchronizer and debouncer for slide switches and push-buttons.
// Each channel accepts a new level only after it has been stable for STABLE_CYCLES clocks.
module switch_debounce #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  typedef enum logic [1:0] {
    IDLE0,
    PEND1,
    IDLE1,
    PEND0
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   clean_q;
    logic                   rise_q;
    logic                   fall_q;

    // Plain flop chain, nothing between stages, so metastability can settle.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw[i]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE0;
        cnt_q   <= '0;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        case (state_q)
          IDLE0: begin
            if (s) begin
              state_q <= PEND1;
              cnt_q   <= CNT_W'(1);
            end
          end
          PEND1: begin
            if (!s) begin
              state_q <= IDLE0;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= IDLE1;
              cnt_q   <= '0;
              clean_q <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          IDLE1: begin
            if (!s) begin
              state_q <= PEND0;
              cnt_q   <= CNT_W'(1);
            end
          end
          PEND0: begin
            // A bounce back to 1 discards all progress toward the 0 level.
            if (s) begin
              state_q <= IDLE1;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= IDLE0;
              cnt_q   <= '0;
              clean_q <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= IDLE0;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign sw_clean[i] = clean_q;
    assign rise[i]     = rise_q;
    assign fall[i]     = fall_q;
  end

endmodule
